// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit MIPS-style pipeline.
// Widths, the NOP encoding and the fetch FSM state type.
package cpu_pkg;

  localparam int unsigned PC_W    = 6;
  localparam int unsigned INSTR_W = 16;

  localparam logic [15:0] NOP = 16'h0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: valid bit plus captured instruction and its PC.
// Squash beats load, load beats consume; otherwise the contents hold.
module ifid_reg
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W    = cpu_pkg::PC_W,
  parameter int unsigned INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               squash,
  input  logic               consume,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (squash) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = instr_in;
      pc_d    = pc_in;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= INSTR_W'(NOP);
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, RUN/HALT FSM, delivered-instruction counter.
// Drives instruction memory combinationally and feeds decode through ifid_reg.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned    PC_W     = cpu_pkg::PC_W,
  parameter int unsigned    INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned    CNT_W    = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  output logic [PC_W-1:0]    IM_ADDR,
  input  logic [INSTR_W-1:0] IM_DATA,
  input  logic               REDIRECT,
  input  logic [PC_W-1:0]    REDIRECT_PC,
  input  logic               HALT_REQ,
  input  logic               RESUME,
  input  logic               ID_READY,
  output logic               ID_VALID,
  output logic [INSTR_W-1:0] ID_INSTR,
  output logic [PC_W-1:0]    ID_PC,
  output logic               HALTED,
  output logic [CNT_W-1:0]   FETCH_CNT
);

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fire;
  logic ifid_load, ifid_squash, ifid_consume;

  assign fire = ID_VALID & ID_READY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // HALT_REQ only matters in RUN; RESUME (with or without REDIRECT) leaves HALT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:  if (HALT_REQ) state_d = HALT;
      HALT: if (RESUME)   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_d         = pc_q;
    ifid_load    = 1'b0;
    ifid_squash  = 1'b0;
    ifid_consume = fire;
    if (REDIRECT) begin
      pc_d        = REDIRECT_PC;
      ifid_squash = 1'b1;
    end else if (state_q == RUN && !HALT_REQ && (!ID_VALID || fire)) begin
      ifid_load = 1'b1;
      pc_d      = pc_q + PC_W'(1);
    end
  end

  // A word squashed by a redirect is not counted even if decode saw ready.
  always_comb begin
    cnt_d = cnt_q;
    if (fire && !REDIRECT) cnt_d = cnt_q + CNT_W'(1);
  end

  ifid_reg #(
    .PC_W   (PC_W),
    .INSTR_W(INSTR_W)
  ) u_ifid (
    .clk     (CLK),
    .rst_n   (RST_N),
    .load    (ifid_load),
    .squash  (ifid_squash),
    .consume (ifid_consume),
    .instr_in(IM_DATA),
    .pc_in   (pc_q),
    .valid   (ID_VALID),
    .instr   (ID_INSTR),
    .pc      (ID_PC)
  );

  assign IM_ADDR   = pc_q;
  assign HALTED    = (state_q == HALT);
  assign FETCH_CNT = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against a cycle-level
// behavioural model of the fetch rules.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [5:0]  IM_ADDR;
  logic [15:0] IM_DATA;
  logic        REDIRECT;
  logic [5:0]  REDIRECT_PC;
  logic        HALT_REQ;
  logic        RESUME;
  logic        ID_READY;
  logic        ID_VALID;
  logic [15:0] ID_INSTR;
  logic [5:0]  ID_PC;
  logic        HALTED;
  logic [15:0] FETCH_CNT;

  logic [15:0] mem [64];

  int errors = 0;
  int checks = 0;

  int m_pc, m_v, m_instr, m_ipc, m_halt, m_cnt;

  fetch_stage #(
    .PC_W    (6),
    .INSTR_W (16),
    .RESET_PC(6'd0),
    .CNT_W   (16)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .IM_ADDR    (IM_ADDR),
    .IM_DATA    (IM_DATA),
    .REDIRECT   (REDIRECT),
    .REDIRECT_PC(REDIRECT_PC),
    .HALT_REQ   (HALT_REQ),
    .RESUME     (RESUME),
    .ID_READY   (ID_READY),
    .ID_VALID   (ID_VALID),
    .ID_INSTR   (ID_INSTR),
    .ID_PC      (ID_PC),
    .HALTED     (HALTED),
    .FETCH_CNT  (FETCH_CNT)
  );

  always #5 CLK = ~CLK;

  assign IM_DATA = mem[IM_ADDR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_v = 0; m_instr = 0; m_ipc = 0; m_halt = 0; m_cnt = 0;
  endtask

  task automatic check_all();
    chk("im_addr",   32'(IM_ADDR),   32'(m_pc));
    chk("id_valid",  32'(ID_VALID),  32'(m_v));
    chk("halted",    32'(HALTED),    32'(m_halt));
    chk("fetch_cnt", 32'(FETCH_CNT), 32'(m_cnt));
    if (m_v != 0) begin
      chk("id_instr", 32'(ID_INSTR), 32'(m_instr));
      chk("id_pc",    32'(ID_PC),    32'(m_ipc));
    end
  endtask

  // One clock: apply the fetch rules to the model, then compare after the edge.
  task automatic step();
    int n_pc, n_v, n_instr, n_ipc, n_halt, n_cnt;
    bit fire;
    n_pc = m_pc; n_v = m_v; n_instr = m_instr; n_ipc = m_ipc;
    n_halt = m_halt; n_cnt = m_cnt;
    fire = (m_v != 0) && ID_READY;
    if (REDIRECT) begin
      n_pc = int'(REDIRECT_PC);
      n_v  = 0;
      n_halt = (m_halt != 0) ? int'(!RESUME) : int'(HALT_REQ);
    end else if (m_halt == 0 && HALT_REQ) begin
      if (fire) begin n_v = 0; n_cnt++; end
      n_halt = 1;
    end else if (m_halt == 0 && (m_v == 0 || fire)) begin
      if (fire) n_cnt++;
      n_instr = int'(mem[m_pc]);
      n_ipc   = m_pc;
      n_v     = 1;
      n_pc    = (m_pc + 1) % 64;
    end else if (m_halt != 0) begin
      if (fire) begin n_v = 0; n_cnt++; end
      if (RESUME) n_halt = 0;
    end
    n_cnt = n_cnt % 65536;
    @(posedge CLK);
    #1;
    m_pc = n_pc; m_v = n_v; m_instr = n_instr; m_ipc = n_ipc;
    m_halt = n_halt; m_cnt = n_cnt;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h2120; mem[1] = 16'h6453; mem[2] = 16'h0786;
    mem[4] = 16'hE76E; mem[5] = 16'h1A2B;

    RST_N = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = '0;
    HALT_REQ = 1'b0; RESUME = 1'b0; ID_READY = 1'b1;
    model_reset();
    #3;
    check_all();
    chk("rst_instr", 32'(ID_INSTR), 32'h0);
    chk("rst_idpc",  32'(ID_PC),    32'h0);
    #9 RST_N = 1'b1;

    // Reset and first fetch, then backpressure on 0x6453.
    step(); chk("first_instr", 32'(ID_INSTR), 32'h2120);
    step(); chk("second_instr", 32'(ID_INSTR), 32'h6453);
    ID_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_instr", 32'(ID_INSTR), 32'h6453);
      chk("bp_idpc",  32'(ID_PC),    32'd1);
      chk("bp_pc",    32'(IM_ADDR),  32'd2);
    end
    ID_READY = 1'b1;
    step(); chk("bp_resume", 32'(ID_INSTR), 32'h0786);
    step(); chk("cnt3", 32'(FETCH_CNT), 32'd3);

    // Redirect while 0xE76E is held.
    step(); chk("e76e", 32'(ID_INSTR), 32'hE76E);
    REDIRECT = 1'b1; REDIRECT_PC = 6'd5; ID_READY = 1'b0;
    step(); chk("redir_bubble", 32'(ID_VALID), 32'd0);
    chk("redir_addr", 32'(IM_ADDR), 32'd5);
    REDIRECT = 1'b0; ID_READY = 1'b1;
    step(); chk("redir_target", 32'(ID_INSTR), 32'h1A2B);
    chk("redir_cnt", 32'(FETCH_CNT), 32'd4);

    // Halt at PC=3 with a pending instruction, drain, resume.
    REDIRECT = 1'b1; REDIRECT_PC = 6'd2; ID_READY = 1'b0;
    step();
    REDIRECT = 1'b0;
    step();
    HALT_REQ = 1'b1;
    step();
    HALT_REQ = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ID_READY = (i >= 4);
      step();
      chk("halt_pc", 32'(IM_ADDR), 32'd3);
      chk("halt_flag", 32'(HALTED), 32'd1);
    end
    chk("halt_drained", 32'(ID_VALID), 32'd0);
    RESUME = 1'b1;
    step();
    RESUME = 1'b0;
    step(); chk("resume_idpc", 32'(ID_PC), 32'd3);

    // PC wrap.
    REDIRECT = 1'b1; REDIRECT_PC = 6'd62;
    step();
    REDIRECT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wrap_idpc", 32'(ID_PC), 32'((62 + i) % 64));
    end

    // Asynchronous reset between edges with PC=7 and a live instruction.
    REDIRECT = 1'b1; REDIRECT_PC = 6'd6;
    step();
    REDIRECT = 1'b0; ID_READY = 1'b0;
    step();
    chk("pre_rst_pc", 32'(IM_ADDR), 32'd7);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_instr", 32'(ID_INSTR), 32'h0);
    #2 RST_N = 1'b1;
    ID_READY = 1'b1;
    step(); chk("restart_idpc", 32'(ID_PC), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      REDIRECT    = ($urandom_range(9) == 0);
      REDIRECT_PC = 6'($urandom_range(63));
      HALT_REQ    = ($urandom_range(15) == 0);
      RESUME      = ($urandom_range(4) == 0);
      ID_READY    = ($urandom_range(9) < 7);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
